key_debounce: RTL and testbench

//  Multi-channel debouncer and edge detector for mechanical push-buttons (board KEYs).

---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_if.sv | 27 ++
 rtl/key_debounce_ch.sv | 141 ++++++++++++++
 rtl/key_debounce.sv | 46 ++++
 tb/tb_key_debounce.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key debouncer.
package key_debounce_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StHeld,
    StRelPend
  } key_state_e;

  // Bits needed to hold values 0..n (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pad / debounced key bundle. The debouncer uses the slave modport;
// pad drivers and consumers use the master modport.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              key_any;

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_any
  );

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_any
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability counter and state machine.
// Optional auto-repeat is built when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  // Pad value when the key is not pressed.
  localparam logic            RawIdle = ACTIVE_LOW;

  logic            sync1_q, sync2_q;
  logic            synced;
  logic [CntW-1:0] cnt_q;
  key_state_e      state_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned HoldMax =
      (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned      HoldW    = cnt_width(HoldMax);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] RepLast  = HoldW'(REPEAT_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  logic [HoldW-1:0] hold_cnt_q;
  logic             rep_q;
  logic             repeat_due;

  // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
  assign repeat_due = (hold_cnt_q == (rep_q ? RepLast : HoldLast));
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

  // Two-flop synchroniser, reset to the released pad level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RawIdle;
      sync2_q <= RawIdle;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // 1 = pressed regardless of pad polarity.
  assign synced = sync2_q ^ ACTIVE_LOW;

  // Debounce FSM with registered level and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReleased;
      cnt_q       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_cnt_q  <= '0;
      rep_q       <= 1'b0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_REPEAT_EN
      // Cleared whenever the channel is not sitting in StHeld.
      hold_cnt_q  <= '0;
      rep_q       <= 1'b0;
`endif
      unique case (state_q)
        StReleased: begin
          if (synced) begin
            state_q <= StPressPend;
            cnt_q   <= CntOne;
          end
        end
        StPressPend: begin
          if (!synced) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= StHeld;
            cnt_q     <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHeld: begin
          if (!synced) begin
            state_q <= StRelPend;
            cnt_q   <= CntOne;
          end else begin
`ifdef KEY_REPEAT_EN
            if (repeat_due) begin
              key_press  <= 1'b1;
              hold_cnt_q <= '0;
              rep_q      <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + HoldOne;
              rep_q      <= rep_q;
            end
`endif
          end
        end
        StRelPend: begin
          if (synced) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StReleased;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StReleased;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer / edge detector.
// Define KEY_REPEAT_EN to build auto-repeat press pulses while a key is held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input logic            clk,
  input logic            rst_n,
  key_debounce_if.slave  keys
);

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_p;

  assign raw = keys.key_raw;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (raw[k]),
      .key_level   (level[k]),
      .key_press   (press[k]),
      .key_release (release_p[k])
    );
  end

  assign keys.key_level   = level;
  assign keys.key_press   = press;
  assign keys.key_release = release_p;
  // Press pulses are already registered, so this is glitch-free in-cycle.
  assign keys.key_any     = |press;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: reference model plus directed literal checks.
module tb_key_debounce;
  localparam int unsigned N = 2;
  localparam int unsigned D = 4;
  localparam int unsigned H = 10;
  localparam int unsigned R = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   checking = 1'b0;

  key_debounce_if #(.N_KEYS(N)) kif ();

  key_debounce #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .keys  (kif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key's level flips once the synchronised pad value
  // (pad sample from two edges earlier) has disagreed with it on the last D
  // edges. Repeats are timed arithmetically from the start of a steady hold.
  bit           samp   [N][D+2];
  bit           lvl    [N];
  bit           anc_ok [N];
  int           anchor [N];
  int           edge_n;
  logic [N-1:0] exp_level, exp_press, exp_release;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n      = 0;
      exp_level   = '0;
      exp_press   = '0;
      exp_release = '0;
      for (int c = 0; c < N; c++) begin
        lvl[c]    = 1'b0;
        anc_ok[c] = 1'b0;
        anchor[c] = 0;
        for (int k = 0; k < D + 2; k++) samp[c][k] = 1'b0;
      end
    end else begin
      edge_n++;
      for (int c = 0; c < N; c++) begin
        bit all_diff;
        bit p;
        bit r;
        p = 1'b0;
        r = 1'b0;
        for (int k = D + 1; k > 0; k--) samp[c][k] = samp[c][k-1];
        samp[c][0] = ~kif.key_raw[c];
        all_diff = 1'b1;
        for (int k = 2; k < D + 2; k++) if (samp[c][k] == lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          lvl[c] = ~lvl[c];
          if (lvl[c]) p = 1'b1;
          else r = 1'b1;
          anc_ok[c] = lvl[c];
          anchor[c] = edge_n;
        end else if (lvl[c]) begin
          if (!samp[c][2]) begin
            anc_ok[c] = 1'b0;
          end else if (!anc_ok[c]) begin
            anc_ok[c] = 1'b1;
            anchor[c] = edge_n;
          end else begin
`ifdef KEY_REPEAT_EN
            int d;
            d = edge_n - anchor[c];
            if (d == int'(H) || (d > int'(H) && (d - int'(H)) % int'(R) == 0)) p = 1'b1;
`endif
          end
        end
        exp_level[c]   = lvl[c];
        exp_press[c]   = p;
        exp_release[c] = r;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("model_level", kif.key_level, exp_level);
      chk("model_press", kif.key_press, exp_press);
      chk("model_release", kif.key_release, exp_release);
      chk("model_any", kif.key_any, |exp_press);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rel_cnt;
    kif.key_raw = 2'b11;
    step(3);
    checking = 1'b1;
    chk("reset_level", kif.key_level, 2'b00);
    chk("reset_press", kif.key_press, 2'b00);
    chk("reset_any", kif.key_any, 1'b0);
    rst_n = 1'b1;

    // 1. idle keys for 20 cycles
    step(20);
    chk("idle_level", kif.key_level, 2'b00);

    // 3. 3-cycle glitch is filtered out
    kif.key_raw = 2'b10;
    step(3);
    kif.key_raw = 2'b11;
    step(10);
    chk("glitch_level", kif.key_level, 2'b00);

    // 2. clean press: pulse exactly 6 edges after the raw edge
    kif.key_raw = 2'b10;
    step(5);
    chk("press_early_level", kif.key_level, 2'b00);
    chk("press_early_pulse", kif.key_press, 2'b00);
    step(1);
    chk("press_pulse", kif.key_press, 2'b01);
    chk("press_level", kif.key_level, 2'b01);
    chk("press_any", kif.key_any, 1'b1);

    // 6. hold 30 cycles: repeats at +10, +13, +16 ... only with auto-repeat
    for (int i = 1; i <= 30; i++) begin
      logic exp_rep;
`ifdef KEY_REPEAT_EN
      exp_rep = (i inside {10, 13, 16, 19, 22, 25, 28});
`else
      exp_rep = 1'b0;
`endif
      step(1);
      chk("hold_press", kif.key_press[0], exp_rep);
    end
    chk("hold_level", kif.key_level, 2'b01);

    // 4. release with bounce 1,0,1,0 then steady 1
    kif.key_raw = 2'b11; step(1);
    kif.key_raw = 2'b10; step(1);
    kif.key_raw = 2'b11; step(1);
    kif.key_raw = 2'b10; step(1);
    kif.key_raw = 2'b11;
    rel_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (kif.key_release[0]) rel_cnt++;
      if (i == 5) chk("release_early", kif.key_release, 2'b00);
      if (i == 6) begin
        chk("release_pulse", kif.key_release, 2'b01);
        chk("release_level", kif.key_level, 2'b00);
      end
    end
    chk("release_count", rel_cnt, 1);

    // 5. both keys pressed in the same cycle
    kif.key_raw = 2'b00;
    step(6);
    chk("both_press", kif.key_press, 2'b11);
    chk("both_any", kif.key_any, 1'b1);
    step(1);
    chk("both_press_end", kif.key_press, 2'b00);
    chk("both_level", kif.key_level, 2'b11);

    // 6b. async reset while held: outputs drop immediately
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_level", kif.key_level, 2'b00);
    chk("rst_mid_press", kif.key_press, 2'b00);
    step(2);
    rst_n = 1'b1;
    // key held through reset release is reported after 2 + D edges
    step(5);
    chk("held_rst_early", kif.key_press, 2'b00);
    step(1);
    chk("held_rst_press", kif.key_press, 2'b11);
    kif.key_raw = 2'b11;
    step(12);
    chk("all_released", kif.key_level, 2'b00);

    // Reset in the middle of a debounce discards the partial count
    kif.key_raw = 2'b01;
    step(3);
    rst_n = 1'b0;
    kif.key_raw = 2'b11;
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("rst_debounce_level", kif.key_level, 2'b00);
    chk("rst_debounce_press", kif.key_press, 2'b00);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
